fft32_twiddle_round: RTL and testbench

FFT32_TWIDDLE_ROUND -- requirements
Module: fft32_twiddle_round

---
 rtl/fft32_pkg.sv | 22 ++
 rtl/fft32_twiddle_round_if.sv | 35 +++
 rtl/fft32_round_sat.sv | 42 ++++
 rtl/fft32_twiddle_round.sv | 100 ++++++++++
 tb/tb_fft32_twiddle_round.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/fft32_pkg.sv
// rtl/fft32_pkg.sv - shared constants and helpers for the FFT32 twiddle rounding stage
package fft32_pkg;

    localparam int FFT_N      = 32;
    localparam int FCNT_W     = $clog2(FFT_N);

    localparam int PROD_W_DEF = 28;
    localparam int DOUT_W_DEF = 14;
    localparam int FRAC_DEF   = 14;

    localparam int SAT_MAX    = (2 ** (DOUT_W_DEF - 1)) - 1;
    localparam int SAT_MIN    = -(2 ** (DOUT_W_DEF - 1));

    function automatic int sat_hi(input int w);
        return (2 ** (w - 1)) - 1;
    endfunction

    function automatic int sat_lo(input int w);
        return -(2 ** (w - 1));
    endfunction

endpackage

// File: rtl/fft32_twiddle_round_if.sv
// rtl/fft32_twiddle_round_if.sv - product-in / rounded-sample-out handshake bundle
//
// master: drives the four products, in_valid and out_ready (producer + consumer side)
// slave : the rounding block; drives in_ready and the output bundle
interface fft32_twiddle_round_if
    import fft32_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int DOUT_W = DOUT_W_DEF
) ();

    logic signed [PROD_W-1:0] p_rr;
    logic signed [PROD_W-1:0] p_ii;
    logic signed [PROD_W-1:0] p_ri;
    logic signed [PROD_W-1:0] p_ir;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DOUT_W-1:0] y_re;
    logic signed [DOUT_W-1:0] y_im;
    logic                     y_sat;
    logic                     y_last;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output p_rr, p_ii, p_ri, p_ir, in_valid, out_ready,
        input  in_ready, y_re, y_im, y_sat, y_last, out_valid
    );

    modport slave (
        input  p_rr, p_ii, p_ri, p_ir, in_valid, out_ready,
        output in_ready, y_re, y_im, y_sat, y_last, out_valid
    );

endinterface

// File: rtl/fft32_round_sat.sv
// rtl/fft32_round_sat.sv - round-half-up shift by FRAC then saturate to DOUT_W
//
// sum  : signed PROD_W+1 bit accumulated product
// dout : signed DOUT_W bit rounded/saturated result
// sat  : dout was clamped
module fft32_round_sat
    import fft32_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int DOUT_W = DOUT_W_DEF,
    parameter int FRAC   = FRAC_DEF
) (
    input  logic signed [PROD_W:0]   sum,
    output logic signed [DOUT_W-1:0] dout,
    output logic                     sat
);

    // One guard bit above the sum so adding the half-LSB bias cannot wrap.
    localparam int EXT_W = PROD_W + 2;
    localparam logic signed [EXT_W-1:0] HALF = EXT_W'(1) << (FRAC - 1);
    localparam logic signed [EXT_W-1:0] HI   = EXT_W'(sat_hi(DOUT_W));
    localparam logic signed [EXT_W-1:0] LO   = EXT_W'(sat_lo(DOUT_W));

    logic signed [EXT_W-1:0] biased;
    logic signed [EXT_W-1:0] shifted;

    always_comb begin
        biased  = EXT_W'(sum) + HALF;
        // Arithmetic shift floors, so an exact half goes toward +inf.
        shifted = biased >>> FRAC;
        dout    = shifted[DOUT_W-1:0];
        sat     = 1'b0;
        if (shifted > HI) begin
            dout = HI[DOUT_W-1:0];
            sat  = 1'b1;
        end else if (shifted < LO) begin
            dout = LO[DOUT_W-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/fft32_twiddle_round.sv
// rtl/fft32_twiddle_round.sv - combine twiddle partial products, round, saturate, frame-tag
//
// ap_clk, ap_rst_n          : clock, asynchronous active-low reset
// p_rr, p_ii, p_ri, p_ir    : signed partial products, qualified by in_valid / in_ready
// y_re, y_im, y_sat, y_last : output sample bundle, qualified by out_valid / out_ready
module fft32_twiddle_round
    import fft32_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int DOUT_W = DOUT_W_DEF,
    parameter int FRAC   = FRAC_DEF
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic signed [PROD_W-1:0] p_rr,
    input  logic signed [PROD_W-1:0] p_ii,
    input  logic signed [PROD_W-1:0] p_ri,
    input  logic signed [PROD_W-1:0] p_ir,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DOUT_W-1:0] y_re,
    output logic signed [DOUT_W-1:0] y_im,
    output logic                     y_sat,
    output logic                     y_last,
    output logic                     out_valid,
    input  logic                     out_ready
);

    logic                     s1_valid;
    logic signed [PROD_W:0]   s1_re;
    logic signed [PROD_W:0]   s1_im;
    logic                     s1_adv;
    logic                     s2_adv;
    logic signed [DOUT_W-1:0] rs_re;
    logic signed [DOUT_W-1:0] rs_im;
    logic                     rs_sat_re;
    logic                     rs_sat_im;
    logic [FCNT_W-1:0]        frame_cnt;

    // A stage may load whenever it is empty or its content leaves this cycle;
    // this lets S2 drain and S1 refill on the same edge without a bubble.
    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s1_valid <= 1'b0;
            s1_re    <= '0;
            s1_im    <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_re <= (PROD_W + 1)'(p_rr) - (PROD_W + 1)'(p_ii);
                s1_im <= (PROD_W + 1)'(p_ri) + (PROD_W + 1)'(p_ir);
            end
        end
    end

    fft32_round_sat #(.PROD_W(PROD_W), .DOUT_W(DOUT_W), .FRAC(FRAC)) u_rs_re (
        .sum  (s1_re),
        .dout (rs_re),
        .sat  (rs_sat_re)
    );

    fft32_round_sat #(.PROD_W(PROD_W), .DOUT_W(DOUT_W), .FRAC(FRAC)) u_rs_im (
        .sum  (s1_im),
        .dout (rs_im),
        .sat  (rs_sat_im)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_valid <= 1'b0;
            y_re      <= '0;
            y_im      <= '0;
            y_sat     <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                y_re  <= rs_re;
                y_im  <= rs_im;
                y_sat <= rs_sat_re | rs_sat_im;
            end
        end
    end

    // Counts delivered samples; it only moves on a transfer, so y_last is
    // stable during a stall.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            frame_cnt <= '0;
        end else if (out_valid && out_ready) begin
            frame_cnt <= frame_cnt + FCNT_W'(1);
        end
    end

    assign y_last = out_valid && (frame_cnt == FCNT_W'(FFT_N - 1));

endmodule

// File: tb/tb_fft32_twiddle_round.sv
// tb/tb_fft32_twiddle_round.sv - self-checking bench for fft32_twiddle_round
module tb_fft32_twiddle_round;

    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;

    always #5 ap_clk = ~ap_clk;

    fft32_twiddle_round_if #(.PROD_W(28), .DOUT_W(14)) bus ();

    fft32_twiddle_round #(.PROD_W(28), .DOUT_W(14), .FRAC(14)) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .p_rr      (bus.p_rr),
        .p_ii      (bus.p_ii),
        .p_ri      (bus.p_ri),
        .p_ir      (bus.p_ir),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .y_re      (bus.y_re),
        .y_im      (bus.y_im),
        .y_sat     (bus.y_sat),
        .y_last    (bus.y_last),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready)
    );

    typedef struct {
        logic signed [27:0] rr;
        logic signed [27:0] ii;
        logic signed [27:0] ri;
        logic signed [27:0] ir;
        logic signed [13:0] re;
        logic signed [13:0] im;
        logic               sat;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    int n_checks = 0;
    int n_errors = 0;
    int m_cnt    = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_sample(input int i);
        bus.p_rr = 28'(i * 16384);
        bus.p_ii = '0;
        bus.p_ri = '0;
        bus.p_ir = -28'(i * 16384);
    endtask

    task automatic do_reset();
        ap_rst_n     = 1'b0;
        bus.in_valid = 1'b0;
        m_cnt        = 0;
        repeat (2) @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
    endtask

    // Back-to-back stream with out_ready=1: checks latency, 1/cycle, data, y_last.
    task automatic run_stream(input int n, input int base);
        int rcv;
        rcv = 0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < n + 2; c++) begin
            if (c < n) begin
                bus.in_valid = 1'b1;
                drive_sample(base + c);
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge ap_clk);
            if (c < n) chk("stream_in_ready", bus.in_ready, 1);
            chk("stream_out_valid", bus.out_valid, (c >= 2) ? 1 : 0);
            if (bus.out_valid) begin
                chk("stream_y_re", bus.y_re, base + rcv);
                chk("stream_y_im", bus.y_im, -(base + rcv));
                chk("stream_y_last", bus.y_last, (m_cnt == 31) ? 1 : 0);
                rcv++;
                m_cnt = (m_cnt + 1) % 32;
            end
            @(posedge ap_clk);
            #1;
        end
        chk("stream_count", rcv, n);
    endtask

    initial begin
        int sent, rcv, cyc;
        logic stalled;
        logic signed [13:0] h_re, h_im;
        logic h_sat, h_last;

        vecs[0]  = '{28'sd1638400, 28'sd0, 28'sd0, -28'sd819200, 14'sd100, -14'sd50, 1'b0};
        vecs[1]  = '{28'sd134217727, -28'sd134217728, 28'sd0, 28'sd0, 14'sd8191, 14'sd0, 1'b1};
        vecs[2]  = '{28'sd0, 28'sd0, -28'sd134217728, -28'sd134217728, 14'sd0, -14'sd8192, 1'b1};
        vecs[3]  = '{28'sd0, 28'sd0, 28'sd0, 28'sd0, 14'sd0, 14'sd0, 1'b0};
        vecs[4]  = '{28'sd8192, 28'sd0, 28'sd0, -28'sd8192, 14'sd1, 14'sd0, 1'b0};
        vecs[5]  = '{28'sd8191, 28'sd0, 28'sd0, -28'sd8193, 14'sd0, -14'sd1, 1'b0};
        vecs[6]  = '{28'sd134201344, 28'sd0, 28'sd0, 28'sd0, 14'sd8191, 14'sd0, 1'b0};
        vecs[7]  = '{28'sd134209536, 28'sd0, 28'sd0, 28'sd0, 14'sd8191, 14'sd0, 1'b1};
        vecs[8]  = '{28'sd0, 28'sd0, -28'sd134217728, 28'sd0, 14'sd0, -14'sd8192, 1'b0};
        vecs[9]  = '{28'sd0, 28'sd0, -28'sd134217728, -28'sd8193, 14'sd0, -14'sd8192, 1'b1};
        vecs[10] = '{28'sd0, 28'sd24576, 28'sd0, 28'sd0, -14'sd1, 14'sd0, 1'b0};
        vecs[11] = '{28'sd0, 28'sd0, 28'sd40960, -28'sd16384, 14'sd0, 14'sd2, 1'b0};

        bus.p_rr = '0; bus.p_ii = '0; bus.p_ri = '0; bus.p_ir = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_y_re", bus.y_re, 0);
        chk("rst_y_im", bus.y_im, 0);
        chk("rst_y_sat", bus.y_sat, 0);
        chk("rst_y_last", bus.y_last, 0);
        do_reset();

        // Directed rounding / saturation vectors, one at a time
        bus.out_ready = 1'b1;
        for (int k = 0; k < NV; k++) begin
            bus.in_valid = 1'b1;
            bus.p_rr = vecs[k].rr;
            bus.p_ii = vecs[k].ii;
            bus.p_ri = vecs[k].ri;
            bus.p_ir = vecs[k].ir;
            @(posedge ap_clk);
            #1 bus.in_valid = 1'b0;
            chk("vec_lat1_out_valid", bus.out_valid, 0);
            @(posedge ap_clk);
            #1;
            chk("vec_lat2_out_valid", bus.out_valid, 1);
            chk($sformatf("vec%0d_y_re", k), bus.y_re, vecs[k].re);
            chk($sformatf("vec%0d_y_im", k), bus.y_im, vecs[k].im);
            chk($sformatf("vec%0d_y_sat", k), bus.y_sat, vecs[k].sat);
            chk($sformatf("vec%0d_y_last", k), bus.y_last, (m_cnt == 31) ? 1 : 0);
            m_cnt = (m_cnt + 1) % 32;
        end
        @(posedge ap_clk);
        #1;

        // Random back-pressure, 40 samples
        do_reset();
        sent = 0; rcv = 0; cyc = 0; stalled = 1'b0;
        h_re = '0; h_im = '0; h_sat = 1'b0; h_last = 1'b0;
        while (rcv < 40 && cyc < 2000) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            if (sent < 40) begin
                bus.in_valid = 1'b1;
                drive_sample(sent);
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge ap_clk);
            if (stalled && bus.out_valid) begin
                chk("bp_stable", ((bus.y_re == h_re) && (bus.y_im == h_im) &&
                    (bus.y_sat == h_sat) && (bus.y_last == h_last)) ? 1 : 0, 1);
            end
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    chk("bp_y_re", bus.y_re, rcv);
                    chk("bp_y_im", bus.y_im, -rcv);
                    chk("bp_y_last", bus.y_last, (m_cnt == 31) ? 1 : 0);
                    rcv++;
                    m_cnt = (m_cnt + 1) % 32;
                    stalled = 1'b0;
                end else begin
                    h_re = bus.y_re; h_im = bus.y_im;
                    h_sat = bus.y_sat; h_last = bus.y_last;
                    stalled = 1'b1;
                end
            end else begin
                stalled = 1'b0;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            @(posedge ap_clk);
            #1;
            cyc++;
        end
        chk("bp_all_received", rcv, 40);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge ap_clk);
        #1 chk("bp_no_extra", bus.out_valid, 0);

        // Framing: 64 back-to-back samples
        do_reset();
        run_stream(64, 0);

        // Mid-stream reset with both stages full
        run_stream(5, 100);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        drive_sample(7);
        @(posedge ap_clk);
        #1 drive_sample(8);
        @(posedge ap_clk);
        #1 bus.in_valid = 1'b0;
        chk("full_out_valid", bus.out_valid, 1);
        chk("full_in_ready", bus.in_ready, 0);
        ap_rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        chk("mid_rst_y_re", bus.y_re, 0);
        chk("mid_rst_y_last", bus.y_last, 0);
        m_cnt = 0;
        @(posedge ap_clk);
        @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge ap_clk);
        chk("post_rst_empty", bus.out_valid, 0);
        @(posedge ap_clk);
        #1;
        run_stream(32, 200);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
